// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and the
// SPI register block address map.
package apb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] RESP   = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StSetup  = SETUP,
    StAccess = ACCESS,
    StResp   = RESP
  } apb_state_e;

  localparam logic [2:0] CR1 = 3'b000;
  localparam logic [2:0] CR2 = 3'b001;
  localparam logic [2:0] BR  = 3'b010;
  localparam logic [2:0] SR  = 3'b011;
  localparam logic [2:0] DR  = 3'b101;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB requester signals of the bridge.
// The master modport is the bridge side; slave is the sequencer/completer side.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;
  logic              PSEL_o;
  logic              PENABLE_o;
  logic              PWRITE_o;
  logic [ADDR_W-1:0] PADDR_o;
  logic [DATA_W-1:0] PWDATA_o;
  logic              PREADY_i;
  logic [DATA_W-1:0] PRDATA_i;
  logic              PSLVERR_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
    input  PREADY_i, PRDATA_i, PSLVERR_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
    output PREADY_i, PRDATA_i, PSLVERR_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns one valid/ready command into a SETUP->ACCESS transfer,
// bounds the PREADY wait, and returns data/error on a valid/ready response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET_n,
  apb_master_bridge_if.master bus
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid_i) begin
          pwrite_d = bus.cmd_write_i;
          paddr_d  = bus.cmd_addr_i;
          pwdata_d = bus.cmd_wdata_i;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // PREADY is checked first so a late ready beats the timeout.
        if (bus.PREADY_i) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA_i;
          rsp_err_d     = bus.PSLVERR_i;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready_i) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  assign bus.cmd_ready_o   = (state_q == StIdle);
  assign bus.PSEL_o        = (state_q == StSetup) || (state_q == StAccess);
  assign bus.PENABLE_o     = (state_q == StAccess);
  assign bus.rsp_valid_o   = (state_q == StResp);
  assign bus.PWRITE_o      = pwrite_q;
  assign bus.PADDR_o       = paddr_q;
  assign bus.PWDATA_o      = pwdata_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench plays sequencer and APB
// completer, with expected responses queued at command time.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET_n = 1'b0;

  apb_master_bridge_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  apb_master_bridge #(
    .ADDR_W (3),
    .DATA_W (8),
    .TIMEOUT(16)
  ) dut (
    .PCLK    (PCLK),
    .PRESET_n(PRESET_n),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } rsp_t;

  rsp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer; waits >= 16 means PREADY never rises before the abort.
  task automatic xfer(input logic w, input logic [2:0] a, input logic [7:0] wd,
                      input int waits, input logic [7:0] rd, input logic err,
                      input int hold);
    rsp_t e;
    int acc;
    int guard;
    int exp_acc;
    e.rdata = (waits >= 16 || w) ? 8'h00 : rd;
    e.err   = (waits >= 16) ? 1'b1 : err;
    e.to    = (waits >= 16);
    exp_acc = (waits >= 16) ? 16 : waits + 1;

    check("idle_ready", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = wd;
    step();
    sb.push_back(e);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = ~a;
    bus.cmd_wdata_i = ~wd;
    check("setup_ctl", {bus.PSEL_o, bus.PENABLE_o, bus.cmd_ready_o}, 3'b100);
    check("setup_addr", {bus.PWRITE_o, bus.PADDR_o, bus.PWDATA_o}, {w, a, wd});
    step();

    acc = 0;
    guard = 0;
    while (bus.PENABLE_o === 1'b1 && guard < 300) begin
      acc++;
      guard++;
      check("access_stable", {bus.PSEL_o, bus.PWRITE_o, bus.PADDR_o, bus.PWDATA_o},
            {1'b1, w, a, wd});
      bus.PREADY_i  = (acc == waits + 1);
      bus.PRDATA_i  = bus.PREADY_i ? rd : ~rd;
      bus.PSLVERR_i = bus.PREADY_i ? err : ~err;
      step();
    end
    bus.PREADY_i  = 1'b0;
    bus.PRDATA_i  = 8'h00;
    bus.PSLVERR_i = 1'b0;
    check("access_bound", guard < 300, 1);
    check("penable_cycles", acc, exp_acc);
    check("resp_ctl", {bus.PSEL_o, bus.PENABLE_o, bus.rsp_valid_o, bus.cmd_ready_o}, 4'b0010);

    // Backpressure: a competing command must be ignored while the response waits.
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_addr_i  = DR;
      check("hold_ready", {bus.rsp_valid_o, bus.cmd_ready_o, bus.PSEL_o}, 3'b100);
      check("hold_rsp", {bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o},
            {sb[0].rdata, sb[0].err, sb[0].to});
      step();
    end
    bus.cmd_valid_i = 1'b0;
    check("no_queue_addr", bus.PADDR_o, a);

    bus.rsp_ready_i = 1'b1;
    check("rsp_valid", bus.rsp_valid_o, 1);
    check("rsp_rdata", bus.rsp_rdata_o, sb[0].rdata);
    check("rsp_err", bus.rsp_err_o, sb[0].err);
    check("rsp_timeout", bus.rsp_timeout_o, sb[0].to);
    void'(sb.pop_front());
    step();
    bus.rsp_ready_i = 1'b0;
    check("back_idle", {bus.rsp_valid_o, bus.cmd_ready_o, bus.PSEL_o}, 3'b010);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    bus.PREADY_i    = 1'b0;
    bus.PRDATA_i    = '0;
    bus.PSLVERR_i   = 1'b0;

    repeat (3) step();
    check("reset_ctl", {bus.cmd_ready_o, bus.rsp_valid_o, bus.PSEL_o, bus.PENABLE_o}, 4'b1000);
    check("reset_regs", {bus.PWRITE_o, bus.PADDR_o, bus.PWDATA_o, bus.rsp_rdata_o,
                         bus.rsp_err_o, bus.rsp_timeout_o}, 0);
    PRESET_n = 1'b1;
    step();

    xfer(1'b1, CR1, 8'h5C, 0, 8'h77, 1'b0, 0);   // write, zero wait
    xfer(1'b0, SR, 8'h00, 3, 8'hA0, 1'b0, 0);    // read, 3 wait states
    xfer(1'b1, CR2, 8'h11, 0, 8'h00, 1'b1, 0);   // slave error
    xfer(1'b0, SR, 8'h00, 16, 8'hEE, 1'b0, 0);   // timeout abort
    xfer(1'b0, BR, 8'h00, 15, 8'h3C, 1'b0, 0);   // ready on the last allowed cycle
    xfer(1'b0, DR, 8'h00, 1, 8'hC3, 1'b1, 5);    // backpressure on response

    // Reset in the middle of ACCESS discards the transfer.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = DR;
    step();
    bus.cmd_valid_i = 1'b0;
    repeat (3) step();
    check("pre_reset_access", {bus.PSEL_o, bus.PENABLE_o}, 2'b11);
    PRESET_n = 1'b0;
    step();
    check("mid_reset", {bus.PSEL_o, bus.PENABLE_o, bus.rsp_valid_o, bus.cmd_ready_o}, 4'b0001);
    PRESET_n = 1'b1;
    step();

    xfer(1'b0, CR1, 8'h00, 2, 8'h96, 1'b0, 1);   // recovery after reset
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester driving the SPI register block's APB interface (CR1/CR2/BR/SR/DR) from a simple valid/ready command port.
- Used by the SoC-side sequencer and by the bench as the bus driver.
- Converts each accepted command into one compliant SETUP→ACCESS transfer, waits for PREADY with a bounded timeout, and returns read data and error status on a valid/ready response port.

Parameters:
- ADDR_W, 3, APB address width (matches the SPI register map).
- DATA_W, 8, APB data width.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; legal range 1..255.

Ports:
- PCLK  in  1  clock
- PRESET_n  in  1  reset; synchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  bridge can accept a command
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  register address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err_o  out  1  PSLVERR seen, or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- PSEL_o  out  1  APB select
- PENABLE_o  out  1  APB enable
- PWRITE_o  out  1  APB direction
- PADDR_o  out  ADDR_W  APB address
- PWDATA_o  out  DATA_W  APB write data
- PREADY_i  in  1  completer ready
- PRDATA_i  in  DATA_W  completer read data
- PSLVERR_i  in  1  completer error

Behaviour:
- All state and outputs are updated on the PCLK rising edge. Reset is sampled synchronously when PRESET_n=0.
- Reset values: every output and every internal register is 0, with two exceptions: state=IDLE and cmd_ready_o=1.
- State machine (2-bit encoding):
  - IDLE: cmd_ready_o=1. cmd_valid_i=1 captures write/addr/wdata into PWRITE_o/PADDR_o/PWDATA_o and moves to SETUP. Otherwise stay in IDLE.
  - SETUP: PSEL_o=1, PENABLE_o=0, cmd_ready_o=0. Always moves to ACCESS next cycle; the wait counter is cleared.
  - ACCESS: PSEL_o=1, PENABLE_o=1.
    - PREADY_i=1: capture PRDATA_i (reads only; writes capture 0) and PSLVERR_i into the response registers, then go to RESP.
    - PREADY_i=0: increment the wait counter. When the counter reaches TIMEOUT-1 with PREADY_i still 0, abort to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - RESP: PSEL_o=0, PENABLE_o=0, rsp_valid_o=1. The response is held stable until rsp_ready_i=1, then the block returns to IDLE.
- Latency: command accepted at cycle T → SETUP at T+1 → ACCESS at T+2. With PREADY_i=1 at T+2, rsp_valid_o=1 at T+3.
  - Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Stability: PADDR_o, PWRITE_o and PWDATA_o are held constant from SETUP through the final ACCESS cycle.
  - After the transfer they keep their last values; they are don't-care while PSEL_o=0.
- PSLVERR_i and PRDATA_i are sampled only in the ACCESS cycle where PREADY_i=1 and are ignored at all other times.
- The rsp_* outputs are registered and change only on entry to RESP.
- Simultaneous events:
  - cmd_valid_i is ignored outside IDLE; commands never queue.
  - If PREADY_i=1 arrives on the same cycle the timeout would fire, PREADY_i wins and the response is normal (rsp_timeout_o=0).
- Wait counter is 8 bits wide and saturates; it never wraps.
- Reset mid-transfer: the next edge forces IDLE and deasserts PSEL_o/PENABLE_o. Any pending response is discarded.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding constants: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, RESP=2'b11;
  - SPI register address constants: CR1=3'b000, CR2=3'b001, BR=3'b010, SR=3'b011, DR=3'b101.
- No sub-module. The FSM, wait counter and response registers live in one module.

Test Plan:
- Write, zero-wait: cmd write addr=3'b000 wdata=8'h5C, PREADY_i=1 → PSEL_o at T+1, PENABLE_o at T+2, PADDR_o=0 and PWDATA_o=8'h5C stable; rsp_valid_o at T+3 with rsp_err_o=0, rsp_rdata_o=0.
- Read with 3 wait states: read addr=3'b011, PREADY_i=1 on the 4th ACCESS cycle with PRDATA_i=8'hA0 → rsp_rdata_o=8'hA0; PENABLE_o high for exactly 4 cycles.
- Slave error: write addr=3'b001, PREADY_i=1 with PSLVERR_i=1 → rsp_err_o=1, rsp_timeout_o=0.
- Timeout: TIMEOUT=16, PREADY_i held 0 → abort after 16 ACCESS cycles; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - Second timeout case: PREADY_i=1 on the 16th cycle → normal response.
- Backpressure: hold rsp_ready_i=0 for 5 cycles → rsp_* stable and cmd_ready_o=0 throughout; the next command is accepted only after the handshake.
- Reset mid-ACCESS: drive PRESET_n=0 for 1 cycle → next edge has PSEL_o=0, PENABLE_o=0, rsp_valid_o=0, cmd_ready_o=1.
